ahb_slave_mem: RTL and testbench
================================

Name: ahb_slave_mem

Overview:
- AHB-Lite subordinate (responder) backed by a word-addressed memory. It is the other end of the AHB master/monitor interface.
- Used as the AHB-side target in the ahb2apb environment: it answers VIP master traffic and gives the DUT bridge a golden reference.
- Implements the address/data pipeline, a fixed number of wait states per transfer, byte-lane writes, and write-to-read forwarding.

Parameters:
- AHB_BUS_W, 32, data bus width in bits; 32 or 64.
- AHB_ADDR_W, 32, address width in bits.
- MEM_DEPTH, 256, number of AHB_BUS_W-bit words; power of 2.
- WAIT_STATES, 0, hready-low cycles inserted per accepted transfer; range 0..15.

Ports:
- clk  input  1  bus clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- hsel  input  1  slave select.
- haddr  input  AHB_ADDR_W  transfer address.
- htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hwrite  input  1  1 = write, 0 = read.
- hsize  input  3  transfer size (log2 of bytes).
- hburst  input  3  burst type; accepted, not decoded.
- hwdata  input  AHB_BUS_W  write data, valid in the data phase.
- hrdata  output  AHB_BUS_W  read data.
- hready  output  1  transfer-done / slave-ready.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: hready=1, hrdata=0, no pending data phase, wait counter=0. Memory array is not reset; its contents are undefined until written.
- Accept rule: a transfer is accepted at a rising edge where hsel=1, htrans[1]=1 and hready=1. At that edge capture the address, hwrite, hsize and byte enables.
- IDLE, BUSY, or hsel=0 at a ready edge: no data phase starts, hready stays 1, memory is untouched.
- Word index = haddr[LSB +: log2(MEM_DEPTH)], where LSB = log2(AHB_BUS_W/8). Upper address bits alias.
- Byte enables: a contiguous block of 2^hsize bytes starting at haddr[LSB-1:0], aligned down to the size.
- Oversize transfer (2^hsize > AHB_BUS_W/8): the transfer completes normally, the write is suppressed and read data is 0.
- State machine:
  - IDLE_ST: hready=1, nothing pending. On accept, go to DATA_ST if WAIT_STATES=0, otherwise WAIT_ST with the counter loaded to WAIT_STATES.
  - WAIT_ST: hready=0. Counter decrements each cycle. When the counter reaches 1, go to DATA_ST at the next edge.
  - DATA_ST: hready=1, final data-phase cycle.
    - A write commits hwdata (enabled bytes only) at this edge.
    - If a new transfer is accepted at the same edge, go to WAIT_ST or DATA_ST as from IDLE_ST; otherwise go to IDLE_ST.
- Throughput: with WAIT_STATES=0, back-to-back transfers run at one per cycle. Each accepted transfer occupies exactly WAIT_STATES+1 data-phase cycles.
- Read data:
  - hrdata is loaded at the accept edge of a read with the memory word, masked to the enabled bytes; non-enabled bytes read 0.
  - hrdata holds its value until the next read is accepted; writes do not change it.
- Forwarding: if a write to the same word index commits at the same edge a read is accepted, its enabled hwdata bytes replace the corresponding memory bytes in the loaded hrdata.
- hburst is ignored. Burst beats are handled as independent transfers; no burst-boundary checking is done.
- Reset mid-transfer: the pending write is dropped, the wait count is cleared and hready goes to 1 asynchronously.

Decomposition:
- Shared package ahb_pkg holds:
  - htrans_e enum (IDLE, BUSY, NONSEQ, SEQ);
  - hsize_e enum (BYTE, HALF, WORD, DWORD);
  - hburst_e enum;
  - function byte_en(addr_lsbs, hsize, bus_bytes), returning the lane mask.
- Sub-module ahb_slave_mem_array: synchronous byte-enable write port plus combinational read port. The parent contains the FSM, counter, capture registers and forwarding mux.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to 0x10 (NONSEQ), immediately read 0x10 in the next cycle -> hready never low; hrdata=0xDEADBEEF in the read data-phase cycle (forwarding path).
- Write word 0x11223344 to 0x20, byte write hsize=0 to 0x23 with hwdata=0xAA000000, read word 0x20 -> hrdata=0xAA223344.
- Write halfword hsize=1 to 0x22 with hwdata=0x55660000, read halfword at 0x22 -> hrdata=0x55660000; a word read then returns upper half 0x5566 and lower half unchanged.
- WAIT_STATES=2: three back-to-back NONSEQ writes -> hready pattern 0,0,1 repeated three times; an IDLE cycle in between produces no wait.
- hsel=0 with htrans=NONSEQ write 0xFFFFFFFF to 0x10, and BUSY with hsel=1 -> hready stays 1; a later read of 0x10 returns the prior value.
- WAIT_STATES=3: assert reset during the 2nd wait cycle of a write to 0x30 -> hready=1 immediately and hrdata=0; a read of 0x30 after reset returns the pre-write value.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and the byte-lane helper used by the slave memory.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    IDLE_ST = 2'd0,
    WAIT_ST = 2'd1,
    DATA_ST = 2'd2
  } slv_state_e;

  // Lane mask for 2^hsize bytes at addr_lsbs, aligned down; zero when oversize.
  function automatic logic [7:0] byte_en(input logic [2:0] addr_lsbs,
                                         input logic [2:0] hsize,
                                         input logic [3:0] bus_bytes);
    logic [7:0] nbytes_s;
    logic [2:0] base_s;
    logic [8:0] run_s;
    logic [7:0] mask_s;
    nbytes_s = 8'd1 << hsize;
    if ({4'd0, bus_bytes} < nbytes_s) begin
      mask_s = 8'h00;
    end else begin
      base_s = addr_lsbs & 3'(bus_bytes - 4'd1) & ~3'(nbytes_s - 8'd1);
      run_s  = (9'd1 << nbytes_s[3:0]) - 9'd1;
      mask_s = run_s[7:0] << base_s;
    end
    return mask_s;
  endfunction

endpackage

// File: rtl/ahb_slave_mem_array.sv
// Word-addressed storage: byte-enable synchronous write, combinational read.
module ahb_slave_mem_array #(
  parameter int W     = 32,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [W/8-1:0]           be,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Byte-lane write port; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < W/8; b++) begin
        if (be[b]) begin
          mem_r[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory subordinate with fixed wait states, byte lanes and
// same-edge write-to-read forwarding.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int AHB_BUS_W   = 32,
  parameter int AHB_ADDR_W  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hsel,
  input  logic [AHB_ADDR_W-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [AHB_BUS_W-1:0]  hwdata,
  output logic [AHB_BUS_W-1:0]  hrdata,
  output logic                  hready
);

  localparam int BYTES = AHB_BUS_W / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  slv_state_e           state_r, next_state_s;
  logic [3:0]           wait_cnt_r, wait_cnt_next_s;
  logic                 hready_r;
  logic [AHB_BUS_W-1:0] hrdata_r, hrdata_next_s, mem_rdata_s;
  logic [IDX_W-1:0]     addr_idx_r, idx_s;
  logic                 write_r;
  logic [BYTES-1:0]     be_r, be_s;
  logic [7:0]           be_full_s;
  logic                 accept_s, we_s;
  logic                 unused_s;

  assign accept_s  = hsel & htrans[1] & hready_r;
  assign idx_s     = haddr[LSB +: IDX_W];
  assign be_full_s = byte_en(haddr[2:0], hsize, 4'(BYTES));
  assign be_s      = be_full_s[BYTES-1:0];
  assign we_s      = (state_r == DATA_ST) & write_r;
  assign unused_s  = ^{hburst, haddr, be_full_s};

  ahb_slave_mem_array #(.W(AHB_BUS_W), .DEPTH(MEM_DEPTH)) u_array (
    .clk   (clk),
    .we    (we_s),
    .be    (be_r),
    .waddr (addr_idx_r),
    .wdata (hwdata),
    .raddr (idx_s),
    .rdata (mem_rdata_s)
  );

  // Next state and wait counter
  always_comb begin
    next_state_s    = state_r;
    wait_cnt_next_s = wait_cnt_r;
    case (state_r)
      IDLE_ST, DATA_ST: begin
        if (!accept_s) begin
          next_state_s = IDLE_ST;
        end else if (WAIT_STATES == 0) begin
          next_state_s = DATA_ST;
        end else begin
          next_state_s    = WAIT_ST;
          wait_cnt_next_s = 4'(WAIT_STATES);
        end
      end
      WAIT_ST: begin
        wait_cnt_next_s = wait_cnt_r - 4'd1;
        if (wait_cnt_r == 4'd1) begin
          next_state_s = DATA_ST;
        end else begin
          next_state_s = WAIT_ST;
        end
      end
      default: begin
        next_state_s    = IDLE_ST;
        wait_cnt_next_s = 4'd0;
      end
    endcase
  end

  // Read data: enabled lanes from memory, overridden by a write committing this edge
  always_comb begin
    hrdata_next_s = hrdata_r;
    if (accept_s && !hwrite) begin
      for (int b = 0; b < BYTES; b++) begin
        if (!be_s[b]) begin
          hrdata_next_s[8*b +: 8] = 8'h00;
        end else if (we_s && be_r[b] && (addr_idx_r == idx_s)) begin
          hrdata_next_s[8*b +: 8] = hwdata[8*b +: 8];
        end else begin
          hrdata_next_s[8*b +: 8] = mem_rdata_s[8*b +: 8];
        end
      end
    end else begin
      hrdata_next_s = hrdata_r;
    end
  end

  // State, counter, registered outputs and address-phase capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE_ST;
      wait_cnt_r <= 4'd0;
      hready_r   <= 1'b1;
      hrdata_r   <= '0;
      addr_idx_r <= '0;
      write_r    <= 1'b0;
      be_r       <= '0;
    end else begin
      state_r    <= next_state_s;
      wait_cnt_r <= wait_cnt_next_s;
      hready_r   <= (next_state_s != WAIT_ST);
      hrdata_r   <= hrdata_next_s;
      if (accept_s) begin
        addr_idx_r <= idx_s;
        write_r    <= hwrite;
        be_r       <= be_s;
      end
    end
  end

  assign hrdata = hrdata_r;
  assign hready = hready_r;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench: three instances (0, 2 and 3 wait states) share one bus driver.
module tb_ahb_slave_mem;
  import ahb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata0, hrdata2, hrdata3;
  logic        hready0, hready2, hready3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ahb_slave_mem #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hrdata(hrdata0), .hready(hready0));

  ahb_slave_mem #(.WAIT_STATES(2)) u_ws2 (
    .clk(clk), .reset(reset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hrdata(hrdata2), .hready(hready2));

  ahb_slave_mem #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hrdata(hrdata3), .hready(hready3));

  task automatic drive(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr);
    hsel = sel; htrans = trans; hwrite = wr; hsize = size; haddr = addr;
  endtask

  task automatic idle();
    drive(1'b0, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1; hburst = 3'd0; hwdata = 32'h0;
    idle();
    @(negedge clk);
    n_cmp++; if (hready0 !== 1'b1) begin n_err++; $display("FAIL rst_hready0 got %b exp 1", hready0); end
    n_cmp++; if (hready2 !== 1'b1) begin n_err++; $display("FAIL rst_hready2 got %b exp 1", hready2); end
    n_cmp++; if (hready3 !== 1'b1) begin n_err++; $display("FAIL rst_hready3 got %b exp 1", hready3); end
    n_cmp++; if (hrdata0 !== 32'h0) begin n_err++; $display("FAIL rst_hrdata0 got %h exp 0", hrdata0); end
    n_cmp++; if (hrdata3 !== 32'h0) begin n_err++; $display("FAIL rst_hrdata3 got %h exp 0", hrdata3); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_forward();
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10);
    @(negedge clk);
    n_cmp++; if (hready0 !== 1'b1) begin n_err++; $display("FAIL fwd_wr_ready got %b exp 1", hready0); end
    hwdata = 32'hDEADBEEF;
    drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
    @(negedge clk);
    n_cmp++; if (hready0 !== 1'b1) begin n_err++; $display("FAIL fwd_rd_ready got %b exp 1", hready0); end
    n_cmp++; if (hrdata0 !== 32'hDEADBEEF) begin n_err++; $display("FAIL fwd_data got %h exp deadbeef", hrdata0); end
    idle();
    @(negedge clk);
  endtask

  task automatic test_byte_lanes();
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h20);
    @(negedge clk);
    hwdata = 32'h11223344;
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h23);
    @(negedge clk);
    hwdata = 32'hAA000000;
    drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20);
    @(negedge clk);
    n_cmp++; if (hrdata0 !== 32'hAA223344) begin n_err++; $display("FAIL byte_merge got %h exp aa223344", hrdata0); end
    hwdata = 32'h0;
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h22);
    @(negedge clk);
    hwdata = 32'h55660000;
    drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_HALF, 32'h22);
    @(negedge clk);
    n_cmp++; if (hrdata0 !== 32'h55660000) begin n_err++; $display("FAIL half_read got %h exp 55660000", hrdata0); end
    drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h20);
    @(negedge clk);
    n_cmp++; if (hrdata0 !== 32'h55663344) begin n_err++; $display("FAIL half_word_read got %h exp 55663344", hrdata0); end
    idle();
    @(negedge clk);
  endtask

  task automatic test_unselected();
    drive(1'b0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10);
    @(negedge clk);
    n_cmp++; if (hready0 !== 1'b1) begin n_err++; $display("FAIL nosel_ready got %b exp 1", hready0); end
    hwdata = 32'hFFFFFFFF;
    drive(1'b1, HTRANS_BUSY, 1'b1, HSIZE_WORD, 32'h10);
    @(negedge clk);
    n_cmp++; if (hready0 !== 1'b1) begin n_err++; $display("FAIL busy_ready got %b exp 1", hready0); end
    drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10);
    @(negedge clk);
    n_cmp++; if (hrdata0 !== 32'hDEADBEEF) begin n_err++; $display("FAIL nosel_keep got %h exp deadbeef", hrdata0); end
    idle();
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] wd [3];
    logic [31:0] wa [3];
    logic        exp_rdy;
    wd[0] = 32'hA5A50001; wd[1] = 32'h5A5A0002; wd[2] = 32'h0F0F0003;
    wa[0] = 32'h40; wa[1] = 32'h44; wa[2] = 32'h48;
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, wa[0]);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i % 3 == 0) begin
        hwdata = wd[i/3];
        if (i / 3 < 2) drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, wa[i/3 + 1]);
        else idle();
      end
      exp_rdy = (i % 3 == 2);
      n_cmp++;
      if (hready2 !== exp_rdy) begin
        n_err++; $display("FAIL ws2_ready cycle %0d got %b exp %b", i, hready2, exp_rdy);
      end
    end
    @(negedge clk);
    n_cmp++; if (hready2 !== 1'b1) begin n_err++; $display("FAIL ws2_idle_nowait got %b exp 1", hready2); end
    drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h40);
    @(negedge clk);
    idle();
    n_cmp++; if (hready2 !== 1'b0) begin n_err++; $display("FAIL ws2_rd_wait got %b exp 0", hready2); end
    n_cmp++; if (hrdata2 !== 32'hA5A50001) begin n_err++; $display("FAIL ws2_rd_data got %h exp a5a50001", hrdata2); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h30);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        hwdata = 32'h12345678;
        drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h30);
      end
      n_cmp++;
      if (hready3 !== (i == 3)) begin n_err++; $display("FAIL ws3_wr_ready cycle %0d got %b", i, hready3); end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        n_cmp++;
        if (hrdata3 !== 32'h12345678) begin n_err++; $display("FAIL ws3_fwd got %h exp 12345678", hrdata3); end
        drive(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h30);
      end
      n_cmp++;
      if (hready3 !== (i == 3)) begin n_err++; $display("FAIL ws3_rd_ready cycle %0d got %b", i, hready3); end
    end
    @(negedge clk);
    hwdata = 32'h99999999;
    idle();
    n_cmp++; if (hready3 !== 1'b0) begin n_err++; $display("FAIL ws3_wait1 got %b exp 0", hready3); end
    @(negedge clk);
    n_cmp++; if (hready3 !== 1'b0) begin n_err++; $display("FAIL ws3_wait2 got %b exp 0", hready3); end
    reset = 1'b1;
    #1;
    n_cmp++; if (hready3 !== 1'b1) begin n_err++; $display("FAIL ws3_rst_ready got %b exp 1", hready3); end
    n_cmp++; if (hrdata3 !== 32'h0) begin n_err++; $display("FAIL ws3_rst_data got %h exp 0", hrdata3); end
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h30);
    @(negedge clk);
    idle();
    n_cmp++; if (hrdata3 !== 32'h12345678) begin n_err++; $display("FAIL ws3_after_rst got %h exp 12345678", hrdata3); end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_byte_lanes();
    test_unselected();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
